// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets and parameter defaults shared by the conditioned GPIO input block
package gpio_pkg;
  // word offsets (HADDR[4:2]) of the register map
  typedef enum logic [2:0] {
    OFF_DATA    = 3'd0,
    OFF_IM      = 3'd1,
    OFF_RISE_EN = 3'd2,
    OFF_FALL_EN = 3'd3,
    OFF_PEND    = 3'd4
  } gpio_off_e;
  localparam int PRESCALE_DEF = 100;
  localparam int DB_SAMPLES_DEF = 3;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
endpackage

// File: rtl/gpio_in_bit.sv
// gpio_in_bit: per-pin 2-flop synchronizer with optional debounce (GPIO_DEBOUNCE_EN)
module gpio_in_bit
  import gpio_pkg::*;
`ifdef GPIO_DEBOUNCE_EN
  #(parameter int DB_SAMPLES = DB_SAMPLES_DEF)
`endif
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic pad,
`ifdef GPIO_DEBOUNCE_EN
  input  logic tick,
`endif
  output logic level
);
  logic [1:0] sync_q;
  // two-stage synchronizer for the asynchronous pad level
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) sync_q <= '0;
    else sync_q <= {sync_q[0], pad};
`ifdef GPIO_DEBOUNCE_EN
  logic [DB_SAMPLES-1:0] hist, hist_n;
  assign hist_n = {hist[DB_SAMPLES-2:0], sync_q[1]};
  // accept a new level only once every sample in the history agrees
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      hist  <= '0;
      level <= 1'b0;
    end else if (tick) begin
      hist  <= hist_n;
      level <= &hist_n ? 1'b1 : ~|hist_n ? 1'b0 : level;
    end
`else
  assign level = sync_q[1];
`endif
endmodule

// File: rtl/ahbl_gpio_incond.sv
// ahbl_gpio_incond: AHB-Lite conditioned GPIO input with edge interrupts; GPIO_DEBOUNCE_EN adds a prescaled debouncer
module ahbl_gpio_incond
  import gpio_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEF,
  parameter int DB_SAMPLES = DB_SAMPLES_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic [31:0] PAD_IN,
  output logic [31:0] GPIO_IN,
  output logic        IRQ
);
  if (PRESCALE < 2 || PRESCALE > 65535 || DB_SAMPLES < 2 || DB_SAMPLES > 8) begin : g_bad_cfg
    $error("ahbl_gpio_incond: PRESCALE or DB_SAMPLES out of range");
  end
`ifdef GPIO_DEBOUNCE_EN
  logic [15:0] pre_cnt;
  logic        tick;
  assign tick = pre_cnt == 16'(PRESCALE - 1);
  // free-running prescaler producing one debounce tick every PRESCALE cycles
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) pre_cnt <= '0;
    else pre_cnt <= tick ? '0 : pre_cnt + 16'd1;
`endif
  for (genvar i = 0; i < 32; i++) begin : g_pin
    gpio_in_bit
`ifdef GPIO_DEBOUNCE_EN
      #(.DB_SAMPLES(DB_SAMPLES))
`endif
      u_bit (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .pad     (PAD_IN[i]),
`ifdef GPIO_DEBOUNCE_EN
        .tick    (tick),
`endif
        .level   (GPIO_IN[i])
      );
  end
  logic        ap_valid, ap_write;
  logic [2:0]  ap_off;
  logic        ap_hit, wr;
  logic [31:0] im, rise_en, fall_en, pend, prev, edge_set, rd_mux;
  logic        unused_ok;
  assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};
  assign ap_hit = HSEL & HREADY & HTRANS[1] & (HSIZE == HSIZE_WORD);
  assign wr = ap_valid & ap_write;
  assign edge_set = (rise_en & ~prev & GPIO_IN) | (fall_en & prev & ~GPIO_IN);
  assign HREADYOUT = 1'b1;
  // latch the address phase; non-word accesses never become valid
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      ap_valid <= 1'b0;
      ap_write <= 1'b0;
      ap_off   <= '0;
    end else if (HREADY) begin
      ap_valid <= ap_hit;
      ap_write <= HWRITE;
      ap_off   <= HADDR[4:2];
    end
  // control registers, edge history, sticky pending bits (set beats W1C) and registered IRQ
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      im      <= '0;
      rise_en <= '0;
      fall_en <= '0;
      pend    <= '0;
      prev    <= '0;
      IRQ     <= 1'b0;
    end else begin
      im      <= wr && ap_off == OFF_IM ? HWDATA : im;
      rise_en <= wr && ap_off == OFF_RISE_EN ? HWDATA : rise_en;
      fall_en <= wr && ap_off == OFF_FALL_EN ? HWDATA : fall_en;
      pend    <= (pend & ~(wr && ap_off == OFF_PEND ? HWDATA : '0)) | edge_set;
      prev    <= GPIO_IN;
      IRQ     <= |(pend & im);
    end
  // data-phase read mux driven from the latched offset
  always_comb begin
    rd_mux = ap_off == OFF_DATA    ? GPIO_IN :
             ap_off == OFF_IM      ? im :
             ap_off == OFF_RISE_EN ? rise_en :
             ap_off == OFF_FALL_EN ? fall_en :
             ap_off == OFF_PEND    ? pend : '0;
    HRDATA = ap_valid && !ap_write ? rd_mux : '0;
  end
endmodule

// File: tb/tb_ahbl_gpio_incond.sv
// tb_ahbl_gpio_incond: scoreboard bench for ahbl_gpio_incond; define GPIO_DEBOUNCE_EN for the debounce build
module tb_ahbl_gpio_incond;
`ifdef GPIO_DEBOUNCE_EN
  localparam int PS = 4;
  localparam int DB = 3;
`else
  localparam int PS = 100;
  localparam int DB = 3;
`endif
  localparam logic [31:0] A_DATA = 32'h00, A_IM = 32'h04, A_RISE = 32'h08, A_FALL = 32'h0C, A_PEND = 32'h10;
  localparam int S_HRDATA = 0, S_GPIO = 1, S_IRQ = 2, S_HREADY = 3;

  logic        HCLK, HRESETn, HWRITE, HREADY, HSEL, HREADYOUT, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA, PAD_IN, GPIO_IN;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;

  ahbl_gpio_incond #(.PRESCALE(PS), .DB_SAMPLES(DB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .PAD_IN(PAD_IN), .GPIO_IN(GPIO_IN), .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    int          cyc;
  } chk_t;
  chk_t q[$];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      act = c.sel == S_HRDATA ? HRDATA : c.sel == S_GPIO ? GPIO_IN :
            c.sel == S_IRQ ? {31'b0, IRQ} : {31'b0, HREADYOUT};
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  always @(negedge HCLK) begin
    n_chk++;
    if (HREADYOUT !== 1'b1) begin
      n_fail++;
      $display("FAIL hreadyout_always: got %b at cycle %0d", HREADYOUT, cyc);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(string name, int sel, logic [31:0] e);
    chk_t c;
    c.name = name;
    c.sel = sel;
    c.exp = e;
    c.cyc = cyc;
    q.push_back(c);
  endtask

  task automatic addr_phase(logic [31:0] a, logic w, logic [2:0] sz);
    HSEL = 1'b1;
    HTRANS = 2'b10;
    HSIZE = sz;
    HWRITE = w;
    HADDR = a;
    tick();
    HSEL = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic wr_sz(logic [31:0] a, logic [31:0] d, logic [2:0] sz);
    addr_phase(a, 1'b1, sz);
    HWDATA = d;
    tick();
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    wr_sz(a, d, 3'b010);
  endtask

  task automatic rd_sz(logic [31:0] a, logic [2:0] sz, string name, logic [31:0] e);
    addr_phase(a, 1'b0, sz);
    chk(name, S_HRDATA, e);
    tick();
  endtask

  task automatic rd(logic [31:0] a, string name, logic [31:0] e);
    rd_sz(a, 3'b010, name, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HSIZE = 3'b010; HWRITE = 1'b0;
    HREADY = 1'b1; HADDR = '0; HWDATA = '0; PAD_IN = '0;
    repeat (3) tick();
    chk("rst_hrdata", S_HRDATA, 32'h0);
    chk("rst_gpio", S_GPIO, 32'h0);
    chk("rst_irq", S_IRQ, 32'h0);
    chk("rst_hreadyout", S_HREADY, 32'h1);
    tick();
    HRESETn = 1'b1;
    tick();
    chk("post_rst_irq", S_IRQ, 32'h0);
    rd(A_PEND, "post_rst_pend", 32'h0);
    // register read/write, size filtering and unmapped offsets
    wr(A_IM, 32'h0000_00A5);
    rd(A_IM, "im_rw", 32'h0000_00A5);
    wr(A_RISE, 32'h1234_5678);
    rd(A_RISE, "rise_rw", 32'h1234_5678);
    wr(A_FALL, 32'h9ABC_DEF0);
    rd(A_FALL, "fall_rw", 32'h9ABC_DEF0);
    wr(A_RISE, 32'h0);
    wr(A_FALL, 32'h0);
    wr_sz(A_IM, 32'hFFFF_FFFF, 3'b000);
    rd(A_IM, "byte_write_ignored", 32'h0000_00A5);
    rd_sz(A_IM, 3'b001, "half_read_zero", 32'h0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd(32'h14, "unmapped_14", 32'h0);
    rd(32'h1C, "unmapped_1c", 32'h0);
    wr(A_DATA, 32'hFFFF_FFFF);
    rd(A_DATA, "data_ro", 32'h0);
    wr(A_IM, 32'h0);
`ifdef GPIO_DEBOUNCE_EN
    // two-tick glitch on pin 5 is rejected, a long stable level is accepted
    wr(A_RISE, 32'h20);
    PAD_IN = 32'h20;
    repeat (8) tick();
    PAD_IN = 32'h0;
    repeat (20) tick();
    chk("glitch_gpio", S_GPIO, 32'h0);
    rd(A_PEND, "glitch_pend", 32'h0);
    PAD_IN = 32'h20;
    repeat (4) tick();
    chk("db_not_yet", S_GPIO, 32'h0);
    repeat (20) tick();
    chk("stable_gpio", S_GPIO, 32'h20);
    rd(A_PEND, "stable_pend", 32'h20);
    wr(A_PEND, 32'h20);
    wr(A_RISE, 32'h0);
`else
    // 2-cycle synchronizer latency
    PAD_IN = 32'h1;
    tick();
    chk("lat_1cyc", S_GPIO, 32'h0);
    tick();
    chk("lat_2cyc", S_GPIO, 32'h1);
    rd(A_DATA, "data_read", 32'h1);
    rd(A_PEND, "no_pend_rise_dis", 32'h0);
    // rising edge with IRQ enabled, then W1C
    PAD_IN = 32'h0;
    repeat (4) tick();
    wr(A_RISE, 32'h1);
    wr(A_IM, 32'h1);
    PAD_IN = 32'h1;
    repeat (3) tick();
    chk("irq_before", S_IRQ, 32'h0);
    tick();
    chk("irq_rise", S_IRQ, 32'h1);
    rd(A_PEND, "pend_rise", 32'h1);
    wr(A_PEND, 32'h1);
    chk("irq_hold_clr", S_IRQ, 32'h1);
    tick();
    chk("irq_cleared", S_IRQ, 32'h0);
    rd(A_PEND, "pend_cleared", 32'h0);
    // falling edge on pin 31 while masked, then unmask
    wr(A_IM, 32'h0);
    wr(A_RISE, 32'h0);
    PAD_IN = 32'h8000_0001;
    repeat (4) tick();
    wr(A_FALL, 32'h8000_0000);
    PAD_IN = 32'h1;
    repeat (4) tick();
    rd(A_PEND, "pend_fall", 32'h8000_0000);
    chk("irq_masked", S_IRQ, 32'h0);
    wr(A_IM, 32'h8000_0000);
    chk("irq_unmask_same", S_IRQ, 32'h0);
    tick();
    chk("irq_unmask_next", S_IRQ, 32'h1);
    wr(A_PEND, 32'h8000_0000);
    wr(A_IM, 32'h0);
    wr(A_FALL, 32'h0);
    // W1C colliding with a new edge on bit 3: the set wins
    wr(A_RISE, 32'h8);
    PAD_IN = 32'h9;
    repeat (4) tick();
    rd(A_PEND, "pend3_first", 32'h8);
    PAD_IN = 32'h1;
    repeat (4) tick();
    rd(A_PEND, "pend3_no_fall", 32'h8);
    PAD_IN = 32'h9;
    tick();
    wr(A_PEND, 32'h8);
    rd(A_PEND, "set_beats_w1c", 32'h8);
    wr(A_PEND, 32'h8);
    rd(A_PEND, "w1c_plain", 32'h0);
    wr(A_RISE, 32'h0);
`endif
    // reset asserted during a data phase with PEND=0xFF
    PAD_IN = 32'h0;
    repeat (30) tick();
    wr(A_RISE, 32'hFF);
    wr(A_IM, 32'hFF);
    PAD_IN = 32'hFF;
    repeat (30) tick();
    rd(A_PEND, "pend_ff", 32'hFF);
    chk("irq_ff", S_IRQ, 32'h1);
    addr_phase(A_PEND, 1'b0, 3'b010);
    #2;
    HRESETn = 1'b0;
    chk("midrst_hrdata", S_HRDATA, 32'h0);
    chk("midrst_irq", S_IRQ, 32'h0);
    chk("midrst_gpio", S_GPIO, 32'h0);
    chk("midrst_hreadyout", S_HREADY, 32'h1);
    tick();
    PAD_IN = 32'h0;
    tick();
    HRESETn = 1'b1;
    tick();
    chk("after_rst_hreadyout", S_HREADY, 32'h1);
    rd(A_IM, "after_rst_im", 32'h0);
    rd(A_RISE, "after_rst_rise", 32'h0);
    rd(A_FALL, "after_rst_fall", 32'h0);
    rd(A_PEND, "after_rst_pend", 32'h0);
    rd(A_DATA, "after_rst_data", 32'h0);
    chk("after_rst_irq", S_IRQ, 32'h0);
    repeat (3) tick();
    while (q.size() > 0) begin
      chk_t c;
      c = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s: never compared, expected %h", c.name, c.exp);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahbl_gpio_incond.md
AHBL_GPIO_INCOND -- requirements
Module: ahbl_gpio_incond

Interface
REQ-001 SHALL have parameter PRESCALE, default 100, meaning HCLK cycles between debounce sample ticks (range 2..65535).
REQ-002 SHALL have parameter DB_SAMPLES, default 3, meaning consecutive equal tick samples needed to accept a new pin level (range 2..8).
REQ-003 SHALL have port HCLK  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port HRESETn  in  1  asynchronous, active-low reset.
REQ-005 SHALL have AHB-Lite slave inputs HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HWRITE, HREADY, HSEL and HWDATA[31:0].
REQ-006 SHALL have port HREADYOUT  out  1  tied high (zero wait states).
REQ-007 SHALL have port HRDATA  out  32  read data.
REQ-008 SHALL have port PAD_IN  in  32  raw asynchronous pad levels.
REQ-009 SHALL have port GPIO_IN  out  32  conditioned levels, which feed the GPIO_IN_x input of a downstream ahbl_gpio.
REQ-010 SHALL have port IRQ  out  1  level interrupt request.

Function
REQ-011 SHALL pass each PAD_IN bit through a 2-flop synchronizer; the second flop output is SYNC.
REQ-012 SHALL capture the address phase (HADDR[4:2], HWRITE, valid) when HSEL & HREADY & HTRANS[1] & HSIZE==3'b010; other HSIZE values SHALL be ignored and read 0.
REQ-013 SHALL apply writes in the cycle after the address phase using HWDATA; HRDATA SHALL be driven combinationally from the latched offset during the data phase.
REQ-014 SHALL implement the register map: 0x00 DATA (RO, = GPIO_IN), 0x04 IM (RW), 0x08 RISE_EN (RW), 0x0C FALL_EN (RW), 0x10 PEND (R, write-1-to-clear); all other offsets read 0 and ignore writes.
REQ-015 SHALL keep a register PREV holding GPIO_IN from the previous cycle.
REQ-016 SHALL set PEND[i] when (RISE_EN[i] & ~PREV[i] & GPIO_IN[i]) | (FALL_EN[i] & PREV[i] & ~GPIO_IN[i]).
REQ-017 SHALL let a set win over a W1C clear on the same bit in the same cycle.
REQ-018 SHALL register IRQ as |(PEND & IM), so it asserts one cycle after PEND and IM are both set.
REQ-019 SHALL leave PEND unaffected by IM; unmasking an already pending bit SHALL raise IRQ on the following cycle.

Reset
REQ-020 SHALL asynchronously clear on HRESETn low: synchronizer flops, PREV, GPIO_IN, IM, RISE_EN, FALL_EN, PEND, IRQ, latched address phase, prescaler and debounce state; HRDATA reads 0 and HREADYOUT stays 1.
REQ-021 SHALL raise no edge in the first cycle after reset release because GPIO_IN and PREV are both 0.

Configuration
REQ-022 SHALL, with GPIO_DEBOUNCE_EN defined, drive a tick every PRESCALE cycles from a 16-bit prescaler; on each tick, per bit, shift SYNC into a DB_SAMPLES-deep history and update GPIO_IN[i] only when the whole history equals the new level.
REQ-023 SHALL, without GPIO_DEBOUNCE_EN, compile out the prescaler and debounce, making GPIO_IN = SYNC (PAD_IN-to-GPIO_IN latency exactly 2 cycles) and ignoring PRESCALE and DB_SAMPLES.

Structure
REQ-024 SHALL place register offset constants (DATA/IM/RISE_EN/FALL_EN/PEND) and parameter defaults in the shared package gpio_pkg.
REQ-025 SHALL place per-pin synchronizer and debounce in one sub-module gpio_in_bit, instantiated 32 times by generate; the AHB register logic SHALL stay in the top module.

Verification
REQ-026 SHALL cover, with no debounce: PAD_IN[0] 0->1 -> GPIO_IN[0]=1 exactly 2 cycles later and DATA read = 0x00000001.
REQ-027 SHALL cover: RISE_EN=0x1, IM=0x1, PAD_IN[0] rising -> PEND=0x1, IRQ high one cycle later; writing PEND 0x1 -> PEND=0, IRQ low next cycle.
REQ-028 SHALL cover: FALL_EN=0x80000000, PAD_IN[31] falling, IM=0 -> PEND=0x80000000, IRQ stays 0; then write IM=0x80000000 -> IRQ=1 next cycle.
REQ-029 SHALL cover: a W1C of bit 3 in the same cycle as a new edge on bit 3 -> PEND[3] remains 1.
REQ-030 SHALL cover, with GPIO_DEBOUNCE_EN, PRESCALE=4, DB_SAMPLES=3: a 2-tick glitch on PAD_IN[5] -> GPIO_IN[5] unchanged and no PEND; a stable 1 held for more than 3 ticks -> GPIO_IN[5]=1.
REQ-031 SHALL cover: HRESETn asserted mid-transfer with PEND=0xFF -> all registers 0, IRQ=0, and HREADYOUT=1 throughout.
